// File: rtl/ezrisc_pkg.sv
// Shared opcode, ALU-op and sequencer-step definitions for the ezrisc control unit.
package ezrisc_pkg;

   localparam int OPC_W = 5;
   localparam int ALU_W = 4;

   localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
   localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
   localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
   localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPC_W-1:0] OP_SHR  = 5'b00101;
   localparam logic [OPC_W-1:0] OP_SHL  = 5'b00110;
   localparam logic [OPC_W-1:0] OP_ROR  = 5'b00111;
   localparam logic [OPC_W-1:0] OP_ROL  = 5'b01000;
   localparam logic [OPC_W-1:0] OP_AND  = 5'b01001;
   localparam logic [OPC_W-1:0] OP_OR   = 5'b01010;
   localparam logic [OPC_W-1:0] OP_ADDI = 5'b01011;
   localparam logic [OPC_W-1:0] OP_ANDI = 5'b01100;
   localparam logic [OPC_W-1:0] OP_ORI  = 5'b01101;
   localparam logic [OPC_W-1:0] OP_MUL  = 5'b01110;
   localparam logic [OPC_W-1:0] OP_DIV  = 5'b01111;
   localparam logic [OPC_W-1:0] OP_NEG  = 5'b10000;
   localparam logic [OPC_W-1:0] OP_NOT  = 5'b10001;
   localparam logic [OPC_W-1:0] OP_IN   = 5'b10101;
   localparam logic [OPC_W-1:0] OP_OUT  = 5'b10110;
   localparam logic [OPC_W-1:0] OP_NOP  = 5'b11001;
   localparam logic [OPC_W-1:0] OP_HALT = 5'b11010;

   localparam logic [ALU_W-1:0] ALU_AND = 4'h0;
   localparam logic [ALU_W-1:0] ALU_OR  = 4'h1;
   localparam logic [ALU_W-1:0] ALU_ADD = 4'h2;
   localparam logic [ALU_W-1:0] ALU_SUB = 4'h3;
   localparam logic [ALU_W-1:0] ALU_SHR = 4'h4;
   localparam logic [ALU_W-1:0] ALU_SHL = 4'h5;
   localparam logic [ALU_W-1:0] ALU_ROR = 4'h6;
   localparam logic [ALU_W-1:0] ALU_ROL = 4'h7;
   localparam logic [ALU_W-1:0] ALU_MUL = 4'h8;
   localparam logic [ALU_W-1:0] ALU_DIV = 4'h9;
   localparam logic [ALU_W-1:0] ALU_NEG = 4'hA;
   localparam logic [ALU_W-1:0] ALU_NOT = 4'hB;

   // T0..T7 are consecutive so execute steps can advance by increment
   typedef enum logic [3:0] {
      S_IDLE, S_HALT, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7
   } step_e;

   typedef enum logic [3:0] {
      CL_LD, CL_LDI, CL_ST, CL_RTYPE, CL_IMM, CL_MULDIV,
      CL_UNARY, CL_IN, CL_OUT, CL_NOP, CL_HALT
   } opclass_e;

   typedef struct packed {
      logic pc_out, pc_in, inc_pc, ir_in, mar_in, mdr_in, mdr_out;
      logic y_in, z_in, z_low_out, z_high_out, hi_in, lo_in, c_out;
      logic gra, grb, grc, r_in, r_out, ba_out;
      logic inport_out, outport_in, read, write;
      logic [ALU_W-1:0] alu_op;
      logic run;
   } ctrl_t;

   function automatic step_e lastStep(input opclass_e cls);
      case (cls)
         CL_LD, CL_ST:                 lastStep = S_T7;
         CL_LDI, CL_RTYPE, CL_IMM:     lastStep = S_T5;
         CL_MULDIV:                    lastStep = S_T6;
         CL_UNARY:                     lastStep = S_T4;
         CL_IN, CL_OUT:                lastStep = S_T3;
         default:                      lastStep = S_T2;
      endcase
   endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bundle between the control unit and the datapath: IR/mem_ready in, every strobe out.
interface control_unit_if;
   import ezrisc_pkg::*;

   logic [31:0]      ir;
   logic             mem_ready;
   logic             pc_out, pc_in, inc_pc, ir_in, mar_in, mdr_in, mdr_out;
   logic             y_in, z_in, z_low_out, z_high_out, hi_in, lo_in, c_out;
   logic             gra, grb, grc, r_in, r_out, ba_out;
   logic             inport_out, outport_in, read, write;
   logic [ALU_W-1:0] alu_op;
   logic             run;

   modport master (
      input  ir, mem_ready,
      output pc_out, pc_in, inc_pc, ir_in, mar_in, mdr_in, mdr_out,
      output y_in, z_in, z_low_out, z_high_out, hi_in, lo_in, c_out,
      output gra, grb, grc, r_in, r_out, ba_out,
      output inport_out, outport_in, read, write, alu_op, run
   );

   modport slave (
      output ir, mem_ready,
      input  pc_out, pc_in, inc_pc, ir_in, mar_in, mdr_in, mdr_out,
      input  y_in, z_in, z_low_out, z_high_out, hi_in, lo_in, c_out,
      input  gra, grb, grc, r_in, r_out, ba_out,
      input  inport_out, outport_in, read, write, alu_op, run
   );

endinterface

// File: rtl/control_unit_decode.sv
// Opcode decoder: instruction class plus the ALU operation that class uses.
module cu_decode
   import ezrisc_pkg::*;
(
   input  logic [OPC_W-1:0] opcode_i,
   output opclass_e         cls_o,
   output logic [ALU_W-1:0] aluOp_o
);

   // Anything not listed falls through to NOP so unknown opcodes simply refetch
   always_comb begin
      cls_o   = CL_NOP;
      aluOp_o = ALU_AND;
      case (opcode_i)
         OP_LD:   begin cls_o = CL_LD;     aluOp_o = ALU_ADD; end
         OP_LDI:  begin cls_o = CL_LDI;    aluOp_o = ALU_ADD; end
         OP_ST:   begin cls_o = CL_ST;     aluOp_o = ALU_ADD; end
         OP_ADD:  begin cls_o = CL_RTYPE;  aluOp_o = ALU_ADD; end
         OP_SUB:  begin cls_o = CL_RTYPE;  aluOp_o = ALU_SUB; end
         OP_SHR:  begin cls_o = CL_RTYPE;  aluOp_o = ALU_SHR; end
         OP_SHL:  begin cls_o = CL_RTYPE;  aluOp_o = ALU_SHL; end
         OP_ROR:  begin cls_o = CL_RTYPE;  aluOp_o = ALU_ROR; end
         OP_ROL:  begin cls_o = CL_RTYPE;  aluOp_o = ALU_ROL; end
         OP_AND:  begin cls_o = CL_RTYPE;  aluOp_o = ALU_AND; end
         OP_OR:   begin cls_o = CL_RTYPE;  aluOp_o = ALU_OR;  end
         OP_ADDI: begin cls_o = CL_IMM;    aluOp_o = ALU_ADD; end
         OP_ANDI: begin cls_o = CL_IMM;    aluOp_o = ALU_AND; end
         OP_ORI:  begin cls_o = CL_IMM;    aluOp_o = ALU_OR;  end
         OP_MUL:  begin cls_o = CL_MULDIV; aluOp_o = ALU_MUL; end
         OP_DIV:  begin cls_o = CL_MULDIV; aluOp_o = ALU_DIV; end
         OP_NEG:  begin cls_o = CL_UNARY;  aluOp_o = ALU_NEG; end
         OP_NOT:  begin cls_o = CL_UNARY;  aluOp_o = ALU_NOT; end
         OP_IN:   cls_o = CL_IN;
         OP_OUT:  cls_o = CL_OUT;
         OP_HALT: cls_o = CL_HALT;
         default: cls_o = CL_NOP;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer; every datapath strobe is decoded from {step, opcode}.
module control_unit
   import ezrisc_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   control_unit_if.master bus
);

   logic [OPC_W-1:0] opcode;
   opclass_e         opClass;
   logic [ALU_W-1:0] decAlu;
   step_e            state_q, state_d;
   ctrl_t            ctrl;
   logic             memWait;

   assign opcode = bus.ir[31:27];

   cu_decode uDecode (
      .opcode_i (opcode),
      .cls_o    (opClass),
      .aluOp_o  (decAlu)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   assign memWait = (state_q == S_T1) ||
                    (opClass == CL_LD && state_q == S_T6) ||
                    (opClass == CL_ST && state_q == S_T7);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: state_d = S_T0;
         S_HALT: state_d = S_HALT;
         S_T0:   state_d = S_T1;
         S_T2: begin
            if (opClass == CL_HALT)     state_d = S_HALT;
            else if (opClass == CL_NOP) state_d = S_T0;
            else                        state_d = S_T3;
         end
         default: begin
            if (memWait && !bus.mem_ready)        state_d = state_q;
            else if (state_q == lastStep(opClass)) state_d = S_T0;
            else                                   state_d = step_e'(state_q + 4'd1);
         end
      endcase
   end

   // Exactly one bus driver per step; alu_op stays 0 unless the step feeds Z
   always_comb begin
      ctrl     = '0;
      ctrl.run = (state_q != S_IDLE) && (state_q != S_HALT);
      case (state_q)
         S_T0: begin
            ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1;
            ctrl.z_in   = 1'b1; ctrl.alu_op = ALU_ADD;
         end
         S_T1: begin
            ctrl.z_low_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
         end
         S_T2: begin
            ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
         end
         S_T3: begin
            case (opClass)
               CL_LD, CL_LDI, CL_ST: begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1; end
               CL_RTYPE, CL_IMM:     begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
               CL_MULDIV:            begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
               CL_UNARY: begin
                  ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = decAlu;
               end
               CL_IN:  begin ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
               CL_OUT: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.outport_in = 1'b1; end
               default: ;
            endcase
         end
         S_T4: begin
            case (opClass)
               CL_LD, CL_LDI, CL_ST, CL_IMM: begin
                  ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = decAlu;
               end
               CL_RTYPE: begin
                  ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = decAlu;
               end
               CL_MULDIV: begin
                  ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = decAlu;
               end
               CL_UNARY: begin ctrl.z_low_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
               default: ;
            endcase
         end
         S_T5: begin
            case (opClass)
               CL_LD, CL_ST:             begin ctrl.z_low_out = 1'b1; ctrl.mar_in = 1'b1; end
               CL_LDI, CL_RTYPE, CL_IMM: begin ctrl.z_low_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
               CL_MULDIV:                begin ctrl.z_low_out = 1'b1; ctrl.lo_in = 1'b1; end
               default: ;
            endcase
         end
         S_T6: begin
            case (opClass)
               CL_LD:     begin ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
               CL_ST:     begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1; end
               CL_MULDIV: begin ctrl.z_high_out = 1'b1; ctrl.hi_in = 1'b1; end
               default: ;
            endcase
         end
         S_T7: begin
            case (opClass)
               CL_LD:   begin ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
               CL_ST:   ctrl.write = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign bus.pc_out     = ctrl.pc_out;
   assign bus.pc_in      = ctrl.pc_in;
   assign bus.inc_pc     = ctrl.inc_pc;
   assign bus.ir_in      = ctrl.ir_in;
   assign bus.mar_in     = ctrl.mar_in;
   assign bus.mdr_in     = ctrl.mdr_in;
   assign bus.mdr_out    = ctrl.mdr_out;
   assign bus.y_in       = ctrl.y_in;
   assign bus.z_in       = ctrl.z_in;
   assign bus.z_low_out  = ctrl.z_low_out;
   assign bus.z_high_out = ctrl.z_high_out;
   assign bus.hi_in      = ctrl.hi_in;
   assign bus.lo_in      = ctrl.lo_in;
   assign bus.c_out      = ctrl.c_out;
   assign bus.gra        = ctrl.gra;
   assign bus.grb        = ctrl.grb;
   assign bus.grc        = ctrl.grc;
   assign bus.r_in       = ctrl.r_in;
   assign bus.r_out      = ctrl.r_out;
   assign bus.ba_out     = ctrl.ba_out;
   assign bus.inport_out = ctrl.inport_out;
   assign bus.outport_in = ctrl.outport_in;
   assign bus.read       = ctrl.read;
   assign bus.write      = ctrl.write;
   assign bus.alu_op     = ctrl.alu_op;
   assign bus.run        = ctrl.run;

endmodule
